// File: rtl/axi4_burst_master.sv
// AXI4 burst initiator: accepts one read or write burst command at a time,
// streams write beats from a local port onto W and read beats from R back to
// a local port, then reports completion and an accumulated error flag.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready high
// AW     | write address presented, waiting for aw_ready
// W      | write beats passed through from the local port
// B      | waiting for the write response
// AR     | read address presented, waiting for ar_ready
// R      | read beats passed through to the local port
// DONE   | one-cycle completion pulse with the error summary
module axi4_burst_master #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 4,
  parameter int MASTER_ID         = 0
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  // command port
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [3:0]                    cmd_len,
  // local write beat port
  input  logic [AXI_DATA_WIDTH-1:0]     wr_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   wr_strb,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  // local read beat port
  output logic [AXI_DATA_WIDTH-1:0]     rd_data,
  output logic                          rd_last,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  // completion
  output logic                          done,
  output logic                          err,
  // AXI4 write address channel
  output logic [AXI_ID_WIDTH-1:0]       aw_id,
  output logic [AXI_ADDRESS_WIDTH-1:0]  aw_addr,
  output logic [7:0]                    aw_len,
  output logic [2:0]                    aw_size,
  output logic [1:0]                    aw_burst,
  output logic                          aw_lock,
  output logic [3:0]                    aw_cache,
  output logic [2:0]                    aw_prot,
  output logic [3:0]                    aw_qos,
  output logic [3:0]                    aw_region,
  output logic                          aw_valid,
  input  logic                          aw_ready,
  // AXI4 write data channel
  output logic [AXI_DATA_WIDTH-1:0]     w_data,
  output logic [AXI_DATA_WIDTH/8-1:0]   w_strb,
  output logic                          w_last,
  output logic                          w_valid,
  input  logic                          w_ready,
  // AXI4 write response channel (BID is not needed with one burst in flight)
  input  logic [1:0]                    b_resp,
  input  logic                          b_valid,
  output logic                          b_ready,
  // AXI4 read address channel
  output logic [AXI_ID_WIDTH-1:0]       ar_id,
  output logic [AXI_ADDRESS_WIDTH-1:0]  ar_addr,
  output logic [7:0]                    ar_len,
  output logic [2:0]                    ar_size,
  output logic [1:0]                    ar_burst,
  output logic                          ar_lock,
  output logic [3:0]                    ar_cache,
  output logic [2:0]                    ar_prot,
  output logic [3:0]                    ar_qos,
  output logic [3:0]                    ar_region,
  output logic                          ar_valid,
  input  logic                          ar_ready,
  // AXI4 read data channel (RID is not needed with one burst in flight)
  input  logic [AXI_DATA_WIDTH-1:0]     r_data,
  input  logic [1:0]                    r_resp,
  input  logic                          r_last,
  input  logic                          r_valid,
  output logic                          r_ready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  // every beat carries the full bus width
  localparam logic [2:0] AX_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));
  localparam logic [AXI_ID_WIDTH-1:0] AX_ID = AXI_ID_WIDTH'(MASTER_ID);

  logic [2:0]                   state;
  logic [AXI_ADDRESS_WIDTH-1:0] addr_q;
  logic [3:0]                   len_q;
  logic [3:0]                   beat_cnt;
  logic                         err_acc;
  logic                         aw_valid_q;
  logic                         ar_valid_q;

  logic last_beat;
  logic w_hs;
  logic r_hs;

  assign last_beat = (beat_cnt == len_q);
  assign w_hs      = w_valid && w_ready;
  assign r_hs      = r_valid && r_ready;

  // Burst sequencer: command capture, address handshakes, beat counting and error accumulation.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      err_acc    <= 1'b0;
      aw_valid_q <= 1'b0;
      ar_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            beat_cnt <= '0;
            err_acc  <= 1'b0;
            if (cmd_write) begin
              aw_valid_q <= 1'b1;
              state      <= S_AW;
            end else begin
              ar_valid_q <= 1'b1;
              state      <= S_AR;
            end
          end
        end
        S_AW: begin
          if (aw_ready) begin
            aw_valid_q <= 1'b0;
            state      <= S_W;
          end
        end
        S_W: begin
          // the counter stops on the final beat so a 16-beat burst never wraps it
          if (w_hs) begin
            if (last_beat) state <= S_B;
            else           beat_cnt <= beat_cnt + 4'd1;
          end
        end
        S_B: begin
          if (b_valid) begin
            err_acc <= err_acc | (b_resp != 2'b00);
            state   <= S_DONE;
          end
        end
        S_AR: begin
          if (ar_ready) begin
            ar_valid_q <= 1'b0;
            state      <= S_R;
          end
        end
        S_R: begin
          // the burst length is ours; a slave RLAST in the wrong place is flagged, not obeyed
          if (r_hs) begin
            err_acc <= err_acc | (r_resp != 2'b00) | (r_last != last_beat);
            if (last_beat) state <= S_DONE;
            else           beat_cnt <= beat_cnt + 4'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Channel outputs: registered address valids, state-gated pass-through for beats.
  always_comb begin
    cmd_ready = (state == S_IDLE);

    aw_id     = AX_ID;
    aw_addr   = addr_q;
    aw_len    = {4'b0000, len_q};
    aw_size   = AX_SIZE;
    aw_burst  = 2'b01;
    aw_lock   = 1'b0;
    aw_cache  = 4'b0000;
    aw_prot   = 3'b000;
    aw_qos    = 4'b0000;
    aw_region = 4'b0000;
    aw_valid  = aw_valid_q;

    ar_id     = AX_ID;
    ar_addr   = addr_q;
    ar_len    = {4'b0000, len_q};
    ar_size   = AX_SIZE;
    ar_burst  = 2'b01;
    ar_lock   = 1'b0;
    ar_cache  = 4'b0000;
    ar_prot   = 3'b000;
    ar_qos    = 4'b0000;
    ar_region = 4'b0000;
    ar_valid  = ar_valid_q;

    w_data    = wr_data;
    w_strb    = wr_strb;
    w_last    = last_beat;
    w_valid   = (state == S_W) && wr_valid;
    wr_ready  = (state == S_W) && w_ready;

    b_ready   = (state == S_B);

    rd_data   = r_data;
    rd_last   = last_beat;
    rd_valid  = (state == S_R) && r_valid;
    r_ready   = (state == S_R) && rd_ready;

    done      = (state == S_DONE);
    err       = (state == S_DONE) && err_acc;
  end

endmodule
